// File: rtl/seq_div.sv
// rtl/seq_div.sv - 32-bit sequential radix-2 restoring divider, signed and unsigned
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous reset, active-high
//   start        request a division; accepted only while idle
//   is_signed    1 = signed two's-complement, 0 = unsigned (latched with start)
//   dividend     dividend operand (latched with start)
//   divisor      divisor operand (latched with start)
//   q            quotient, registered, held until the next completion
//   r            remainder, registered, held until the next completion
//   busy         high while iterating
//   done         one-cycle pulse when q/r are updated
//   div_by_zero  high together with done when the latched divisor was zero

module seq_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [4:0]  cnt;
  logic        sgn;
  logic        dvd_neg;
  logic        dvs_neg;
  logic        dz;
  logic [31:0] dvs_mag;
  logic [31:0] rem;
  logic [31:0] quo;

  // Operand magnitudes at the accepting edge
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;

  // One restoring iteration
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // Sign-corrected results for the final iteration
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  logic accept;
  logic last_iter;

  assign accept    = (state == S_IDLE) && start;
  assign last_iter = (state == S_CALC) && (cnt == 5'd31);

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_comb begin
    dvd_abs = dividend;
    dvs_abs = divisor;
    if (is_signed && dividend[31]) dvd_abs = 32'd0 - dividend;
    if (is_signed && divisor[31])  dvs_abs = 32'd0 - divisor;
  end

  // The partial remainder is always below the divisor magnitude, so the
  // shifted value fits 33 bits and bit 32 of the difference is the borrow.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs_mag};
    rem_nxt = diff[32] ? shifted[31:0] : diff[31:0];
    quo_nxt = {quo[30:0], ~diff[32]};
  end

  // A zero divisor makes every trial subtraction succeed, leaving the
  // dividend magnitude as remainder; re-applying the dividend sign then
  // restores the original dividend. The quotient is forced to all ones.
  // The most-negative / -1 case needs no special handling: the magnitude
  // quotient 0x80000000 negates to itself.
  always_comb begin
    q_fix = quo_nxt;
    r_fix = rem_nxt;
    if (sgn && (dvd_neg ^ dvs_neg)) q_fix = 32'd0 - quo_nxt;
    if (sgn && dvd_neg)             r_fix = 32'd0 - rem_nxt;
    if (dz)                         q_fix = 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 5'd0;
      sgn         <= 1'b0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      dz          <= 1'b0;
      dvs_mag     <= 32'd0;
      rem         <= 32'd0;
      quo         <= 32'd0;
      q           <= 32'd0;
      r           <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt     <= 5'd0;
      sgn     <= is_signed;
      dvd_neg <= is_signed & dividend[31];
      dvs_neg <= is_signed & divisor[31];
      dz      <= (divisor == 32'd0);
      dvs_mag <= dvs_abs;
      rem     <= 32'd0;
      quo     <= dvd_abs;
    end else if (state == S_CALC) begin
      cnt <= cnt + 5'd1;
      rem <= rem_nxt;
      quo <= quo_nxt;
      if (last_iter) begin
        q           <= q_fix;
        r           <= r_fix;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = signed two's-complement (DIV), 0 = unsigned (DIVU); latched with start.
REQ-006 dividend  input  32  dividend operand; latched with start.
REQ-007 divisor  input  32  divisor operand; latched with start.
REQ-008 q  output  32  quotient, registered.
REQ-009 r  output  32  remainder, registered.
REQ-010 busy  output  1  high while iterating.
REQ-011 done  output  1  one-cycle pulse when q/r are updated.
REQ-012 div_by_zero  output  1  high together with done when the latched divisor was 0.

Function
REQ-013 The block SHALL implement a state machine IDLE -> CALC -> DONE -> IDLE.
- IDLE: waits for start.
- CALC: 32 radix-2 restoring iterations, one per cycle, driven by a 5-bit counter 0..31.
- DONE: exactly one cycle.
REQ-014 Start SHALL be accepted only in IDLE. Start in CALC or DONE SHALL be ignored, with no queuing.
REQ-015 On the accepting edge k, the block SHALL latch is_signed, sign flags, and the absolute values of the operands (absolute values when signed, raw values when unsigned). Later operand changes SHALL have no effect.
REQ-016 Latency SHALL be as follows:
- busy = 1 after edges k..k+31 (32 cycles).
- After edge k+32: state = DONE, busy = 0, done = 1, and q/r/div_by_zero are updated.
- After edge k+33: IDLE, done = 0.
REQ-017 Each CALC iteration SHALL shift {rem, quo} left by one and trial-subtract the divisor magnitude from the 33-bit partial remainder. If the result is non-negative, it SHALL keep the difference and set the quotient bit to 1; otherwise it SHALL restore and set the bit to 0.
REQ-018 Signed sign fixup SHALL be applied when entering DONE:
- The quotient is negated when the dividend and divisor signs differ.
- The remainder takes the sign of the dividend.
- Magnitudes satisfy |r| < |divisor|.
REQ-019 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield q = 0x80000000 and r = 0, with div_by_zero = 0.
REQ-020 When the divisor is 0, the block SHALL use the full 33-cycle latency and set q = 0xFFFFFFFF, r = the original dividend, and div_by_zero = 1, for both signed and unsigned.
REQ-021 q, r and div_by_zero SHALL hold their last values until the next DONE. They SHALL NOT change during CALC.
REQ-022 done and busy SHALL never be high in the same cycle.
REQ-023 A new start SHALL be accepted on the edge immediately after DONE, i.e. in IDLE at edge k+34 at the earliest.

Reset
REQ-024 Reset SHALL have priority over all other inputs, including start.
REQ-025 On reset, after the next edge: state = IDLE, counter = 0, internal operand registers = 0, busy = 0, done = 0, div_by_zero = 0, q = 0, r = 0.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no done pulse. Start asserted together with reset SHALL be ignored.

Verification
REQ-027 Unsigned 100 / 7 -> q = 14, r = 2, done exactly at edge k+32, busy high for exactly 32 cycles.
REQ-028 Signed 0xFFFFFFF9 (-7) / 2 -> q = 0xFFFFFFFD (-3), r = 0xFFFFFFFF (-1). Signed 7 / 0xFFFFFFFE (-2) -> q = 0xFFFFFFFD, r = 1.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0. Unsigned 0xFFFFFFFF / 1 -> q = 0xFFFFFFFF, r = 0.
REQ-030 Unsigned 5 / 0 -> q = 0xFFFFFFFF, r = 5, div_by_zero = 1 with done. Signed 0xFFFFFFF0 / 0 -> q = 0xFFFFFFFF, r = 0xFFFFFFF0, div_by_zero = 1.
REQ-031 Start 100 / 7, then re-assert start with 50 / 5 and change the operands at cycle 10 -> result still q = 14, r = 2; second start ignored; exactly one done pulse.
REQ-032 Start 100 / 7, assert reset at cycle 10 -> after the next edge busy = 0, q = 0, r = 0, and no done pulse. A following start 9 / 3 -> q = 3, r = 0 after 33 edges.
